hazard_forwarding_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage MIPS core, sitting between ID and the EX/MEM/WB stage registers.

---
 rtl/hazard_forwarding_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_forwarding_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forwarding_ctrl.sv
// rtl/hazard_forwarding_ctrl.sv - MIPS 5-stage hazard/forwarding controller.
// Optional stall-cycle perf counter enabled by HAZARD_PERF_CNT_EN.
module hazard_forwarding_ctrl #(
  parameter int MULDIV_LATENCY = 4,
  parameter int PERF_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_rf_enable,
  input  logic              mem_rf_enable,
  input  logic              wb_rf_enable,
  input  logic [4:0]        ex_rd,
  input  logic [4:0]        mem_rd,
  input  logic [4:0]        wb_rd,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              ex_load_instr,
  input  logic              id_store_instr,
  input  logic              id_muldiv_start,
  input  logic              id_hilo_read,
  output logic [1:0]        forward_mx1,
  output logic [1:0]        forward_mx2,
  output logic [1:0]        forward_mx3,
  output logic              pc_le,
  output logic              npc_le,
  output logic              if_id_le,
  output logic              cu_s,
  output logic              muldiv_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam logic [3:0] LAT = 4'(MULDIV_LATENCY);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       load_haz;
  logic       stall;

  // Youngest producer wins: EX > MEM > WB; $0 never matches.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       ex_en,  input logic [4:0] ex_d,
    input logic       mem_en, input logic [4:0] mem_d,
    input logic       wb_en,  input logic [4:0] wb_d
  );
    if (src == 5'd0)                    return 2'b00;
    else if (ex_en  && ex_d  == src)    return 2'b01;
    else if (mem_en && mem_d == src)    return 2'b10;
    else if (wb_en  && wb_d  == src)    return 2'b11;
    else                                return 2'b00;
  endfunction

  always_comb begin
    load_haz = ex_load_instr && ex_rf_enable && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs) || ((ex_rd == id_rt) && !id_store_instr));
    stall    = load_haz ||
               ((state == MD_BUSY) && (id_hilo_read || id_muldiv_start));

    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (id_muldiv_start && !load_haz) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = LAT;
        end
      end
      MD_BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase

    forward_mx1 = 2'b00;
    forward_mx2 = 2'b00;
    pc_le       = 1'b1;
    npc_le      = 1'b1;
    if_id_le    = 1'b1;
    cu_s        = 1'b0;
    muldiv_busy = 1'b0;
    if (!reset) begin
      forward_mx1 = fwd_sel(id_rs, ex_rf_enable, ex_rd, mem_rf_enable, mem_rd,
                            wb_rf_enable, wb_rd);
      forward_mx2 = fwd_sel(id_rt, ex_rf_enable, ex_rd, mem_rf_enable, mem_rd,
                            wb_rf_enable, wb_rd);
      pc_le       = !stall;
      npc_le      = !stall;
      if_id_le    = !stall;
      cu_s        = stall;
      muldiv_busy = (state == MD_BUSY);
    end
    forward_mx3 = forward_mx2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset)
      perf_q <= '0;
    else if (stall && !(&perf_q))
      perf_q <= perf_q + 1'b1;
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_forwarding_ctrl.sv
// tb/tb_hazard_forwarding_ctrl.sv - self-checking bench for hazard_forwarding_ctrl.
module tb_hazard_forwarding_ctrl;
  localparam int LAT    = 4;
  localparam int PERF_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ex_en, mem_en, wb_en, ld, st, start, hilo;
  logic [4:0] ex_rd, mem_rd, wb_rd, rs, rt;
  logic [1:0] mx1, mx2, mx3;
  logic pc_le, npc_le, if_id_le, cu_s, busy;
  logic [PERF_W-1:0] stall_cycles;

  hazard_forwarding_ctrl #(.MULDIV_LATENCY(LAT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .ex_rf_enable(ex_en), .mem_rf_enable(mem_en), .wb_rf_enable(wb_en),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .id_rs(rs), .id_rt(rt),
    .ex_load_instr(ld), .id_store_instr(st), .id_muldiv_start(start),
    .id_hilo_read(hilo), .forward_mx1(mx1), .forward_mx2(mx2), .forward_mx3(mx3),
    .pc_le(pc_le), .npc_le(npc_le), .if_id_le(if_id_le), .cu_s(cu_s),
    .muldiv_busy(busy), .stall_cycles(stall_cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: busy window derived from the cycle index of the last accepted MULT/DIV.
  int cyc = 0;
  int acc_cyc = -1000;
  int perf = 0;
  logic m_lh, m_busy, m_stall;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    logic       en [3];
    logic [4:0] rd [3];
    en[0] = ex_en;  rd[0] = ex_rd;
    en[1] = mem_en; rd[1] = mem_rd;
    en[2] = wb_en;  rd[2] = wb_rd;
    if (src == 0) return 2'd0;
    for (int i = 0; i < 3; i++)
      if (en[i] && rd[i] == src) return 2'(i + 1);
    return 2'd0;
  endfunction

  task automatic settle_check();
    logic [1:0] e1, e2;
    int eperf;
    #2;
    m_lh    = ld && ex_en && ex_rd != 0 && (ex_rd == rs || (ex_rd == rt && !st));
    m_busy  = !reset && cyc > acc_cyc && cyc <= acc_cyc + LAT;
    m_stall = !reset && (m_lh || (m_busy && (hilo || start)));
    e1 = reset ? 2'd0 : ref_fwd(rs);
    e2 = reset ? 2'd0 : ref_fwd(rt);
`ifdef HAZARD_PERF_CNT_EN
    eperf = perf;
`else
    eperf = 0;
`endif
    check("model_mx1", 32'(mx1), 32'(e1));
    check("model_mx2", 32'(mx2), 32'(e2));
    check("model_mx3", 32'(mx3), 32'(e2));
    check("model_le_cus", {28'd0, pc_le, npc_le, if_id_le, cu_s},
          m_stall ? 32'b0001 : 32'b1110);
    check("model_busy", 32'(busy), 32'(m_busy));
    check("model_perf", 32'(stall_cycles), 32'(eperf));
  endtask

  task automatic advance();
    if (reset) begin
      acc_cyc = -1000;
      perf = 0;
    end else begin
      if (start && !m_lh && !m_busy) acc_cyc = cyc;
      if (m_stall && perf < (1 << PERF_W) - 1) perf++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset = 0; ex_en = 0; mem_en = 0; wb_en = 0; ld = 0; st = 0; start = 0; hilo = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; rs = 0; rt = 0;
  endtask

  typedef struct {
    logic ex_en, mem_en, wb_en;
    logic [4:0] ex_rd, mem_rd, wb_rd, rs, rt;
    logic ld, st;
    logic [1:0] e_mx1, e_mx2;
    logic e_stall;
  } vec_t;

  function automatic vec_t mk(input logic a, b, c, input logic [4:0] d, e, f, g, h,
                              input logic i, j, input logic [1:0] k, l, input logic m);
    vec_t v;
    v.ex_en = a; v.mem_en = b; v.wb_en = c; v.ex_rd = d; v.mem_rd = e; v.wb_rd = f;
    v.rs = g; v.rt = h; v.ld = i; v.st = j; v.e_mx1 = k; v.e_mx2 = l; v.e_stall = m;
    return v;
  endfunction

  vec_t vecs[10];
  int n_stall;

  initial begin
    //            ex mem wb  exrd memrd wbrd rs  rt  ld st  mx1    mx2   stall
    vecs[0] = mk(1, 1, 0,  5,  5,  0,  5,  0, 0, 0, 2'b01, 2'b00, 0);
    vecs[1] = mk(0, 1, 0,  5,  5,  0,  5,  0, 0, 0, 2'b10, 2'b00, 0);
    vecs[2] = mk(0, 0, 1,  0,  0,  0,  0,  0, 0, 0, 2'b00, 2'b00, 0);
    vecs[3] = mk(1, 0, 0,  8,  0,  0,  0,  8, 1, 0, 2'b00, 2'b01, 1);
    vecs[4] = mk(1, 0, 0,  8,  0,  0,  0,  8, 1, 1, 2'b00, 2'b01, 0);
    vecs[5] = mk(0, 1, 1,  0,  7,  7,  7,  7, 0, 0, 2'b10, 2'b10, 0);
    vecs[6] = mk(0, 0, 1,  0,  0,  3,  3,  4, 0, 0, 2'b11, 2'b00, 0);
    vecs[7] = mk(0, 0, 0,  9,  0,  0,  9,  0, 1, 0, 2'b00, 2'b00, 0);
    vecs[8] = mk(1, 0, 0,  0,  0,  0,  0,  0, 1, 0, 2'b00, 2'b00, 0);
    vecs[9] = mk(1, 0, 0,  6,  0,  0,  6,  6, 1, 1, 2'b01, 2'b01, 1);

    clr();
    reset = 1;
    @(posedge clk); #1;
    // Reset forces outputs even with matching producers present.
    ex_en = 1; ex_rd = 5; rs = 5; ld = 1; rt = 5;
    settle_check();
    check("reset_mx1", 32'(mx1), 0);
    check("reset_le", {29'd0, pc_le, npc_le, if_id_le}, 32'b111);
    check("reset_cus", 32'(cu_s), 0);
    advance();
    clr();

    foreach (vecs[i]) begin
      ex_en = vecs[i].ex_en; mem_en = vecs[i].mem_en; wb_en = vecs[i].wb_en;
      ex_rd = vecs[i].ex_rd; mem_rd = vecs[i].mem_rd; wb_rd = vecs[i].wb_rd;
      rs = vecs[i].rs; rt = vecs[i].rt; ld = vecs[i].ld; st = vecs[i].st;
      settle_check();
      check($sformatf("vec%0d_mx1", i), 32'(mx1), 32'(vecs[i].e_mx1));
      check($sformatf("vec%0d_mx2", i), 32'(mx2), 32'(vecs[i].e_mx2));
      check($sformatf("vec%0d_mx3", i), 32'(mx3), 32'(vecs[i].e_mx2));
      check($sformatf("vec%0d_stall", i), {28'd0, pc_le, npc_le, if_id_le, cu_s},
            vecs[i].e_stall ? 32'b0001 : 32'b1110);
      advance();
    end

    // MULT then MFHI held: LAT stall cycles, issue on the following cycle.
    clr(); reset = 1; settle_check(); advance();
    clr(); start = 1; settle_check();
    check("md_start_nostall", 32'(cu_s), 0);
    advance();
    start = 0; hilo = 1;
    for (int i = 0; i < LAT; i++) begin
      settle_check();
      check($sformatf("md_busy_c%0d", i), {30'd0, busy, cu_s}, 32'b11);
      check($sformatf("md_le_c%0d", i), {29'd0, pc_le, npc_le, if_id_le}, 0);
      advance();
    end
    settle_check();
    check("md_release", {28'd0, busy, pc_le, npc_le, if_id_le}, 32'b0111);
`ifdef HAZARD_PERF_CNT_EN
    check("md_perf", 32'(stall_cycles), LAT);
`else
    check("md_perf", 32'(stall_cycles), 0);
`endif
    advance();

    // Reset two cycles into MD_BUSY.
    clr(); start = 1; settle_check(); advance();
    start = 0;
    for (int i = 0; i < 2; i++) begin settle_check(); advance(); end
    reset = 1; hilo = 1; settle_check();
    check("rst_mid_busy_forced", 32'(busy), 0);
    advance();
    reset = 0; settle_check();
    check("rst_mid_busy_after", {30'd0, busy, cu_s}, 0);
    advance();

    // Load-use and MULT start together: stall, retry accepted next cycle.
    clr(); ld = 1; ex_en = 1; ex_rd = 4; rs = 4; start = 1;
    settle_check();
    check("lu_md_stall", 32'(cu_s), 1);
    advance();
    ld = 0; settle_check();
    check("lu_md_retry", {30'd0, busy, cu_s}, 0);
    advance();
    settle_check();
    check("lu_md_accepted", 32'(busy), 1);
    // New MULT held behind the busy one, no overlap.
    n_stall = 0;
    for (int i = 0; i < LAT + 2 && cu_s; i++) begin
      n_stall++;
      advance();
      settle_check();
    end
    check("md_b2b_stalls", n_stall, LAT);
    advance();
    clr(); settle_check();
    check("md_b2b_accepted", 32'(busy), 1);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 39) == 0);
      ex_en  = $urandom_range(0, 1); mem_en = $urandom_range(0, 1); wb_en = $urandom_range(0, 1);
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3)); rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
      ld     = ($urandom_range(0, 3) == 0); st = $urandom_range(0, 1);
      start  = ($urandom_range(0, 5) == 0); hilo = ($urandom_range(0, 2) == 0);
      settle_check();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
